// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for a word-addressed
// asynchronous data memory. A byte-addressed request is range/alignment checked,
// then sequenced SETUP -> ACCESS -> HOLD -> RESP so that the address and write
// data are stable around the enable pulse and ren/wen are never high together.
// Optional build macro: LSU_PERF_COUNTERS_EN adds saturating load/store/error
// counters; without it the counter ports are tied to zero.
module load_store_unit #(
    parameter int ACCESS_CYCLES  = 1,
    parameter int WORD_ADDR_BITS = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic [31:0] cnt_reads,
    output logic [31:0] cnt_writes,
    output logic [31:0] cnt_errors
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4
    } state_t;

    // Enable pulse length; 4 bits covers the legal 1..15 range.
    localparam logic [3:0] ACC_LEN = 4'(ACCESS_CYCLES);

    state_t      state_q, state_d;
    logic        is_write_q, is_write_d;
    logic [3:0]  acc_cnt_q, acc_cnt_d;
    logic        mem_ren_q, mem_ren_d;
    logic        mem_wen_q, mem_wen_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_din_q, mem_din_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        accept;
    logic        req_bad;

    assign accept  = (state_q == IDLE) && req_valid;
    // Misaligned, or any address bit above the usable word range is set.
    assign req_bad = (req_addr[1:0] != 2'b00) ||
                     ((req_addr >> (WORD_ADDR_BITS + 2)) != 32'd0);

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_ren    = mem_ren_q;
    assign mem_wen    = mem_wen_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: errors skip the memory entirely; ACCESS exits on its last cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = req_bad ? RESP : SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (acc_cnt_q == 4'd1) state_d = HOLD;
            HOLD:    state_d = RESP;
            RESP:    if (resp_valid_q && resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath: everything is registered, computed one cycle ahead of state.
    always_comb begin
        is_write_d   = is_write_q;
        acc_cnt_d    = acc_cnt_q;
        mem_ren_d    = mem_ren_q;
        mem_wen_d    = mem_wen_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    is_write_d   = req_write;
                    resp_rdata_d = 32'd0;
                    resp_err_d   = req_bad;
                    // Address/data go out during SETUP, ahead of any enable edge.
                    if (!req_bad) begin
                        mem_addr_d = {2'b00, req_addr[31:2]};
                        mem_din_d  = req_write ? req_wdata : 32'd0;
                    end
                end
            end
            SETUP: begin
                acc_cnt_d = ACC_LEN;
                mem_wen_d = is_write_q;
                mem_ren_d = !is_write_q;
            end
            ACCESS: begin
                if (acc_cnt_q == 4'd1) begin
                    mem_ren_d    = 1'b0;
                    mem_wen_d    = 1'b0;
                    resp_rdata_d = is_write_q ? 32'd0 : mem_dout;
                end else begin
                    acc_cnt_d = acc_cnt_q - 4'd1;
                end
            end
            HOLD: begin
                resp_valid_d = 1'b1;
            end
            RESP: begin
                // Error responses arrive here with valid low; raise it one cycle later.
                if (!resp_valid_q) begin
                    resp_valid_d = 1'b1;
                end else if (resp_ready) begin
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                mem_ren_d    = 1'b0;
                mem_wen_d    = 1'b0;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // Registered outputs and request context; reset abandons any access in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            is_write_q   <= 1'b0;
            acc_cnt_q    <= 4'd0;
            mem_ren_q    <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_din_q    <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            is_write_q   <= is_write_d;
            acc_cnt_q    <= acc_cnt_d;
            mem_ren_q    <= mem_ren_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

`ifdef LSU_PERF_COUNTERS_EN
    logic [31:0] cnt_reads_q, cnt_reads_d;
    logic [31:0] cnt_writes_q, cnt_writes_d;
    logic [31:0] cnt_errors_q, cnt_errors_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Count on the acceptance edge, classified by the same check the FSM uses.
    always_comb begin
        cnt_reads_d  = cnt_reads_q;
        cnt_writes_d = cnt_writes_q;
        cnt_errors_d = cnt_errors_q;
        if (accept) begin
            if (req_bad)        cnt_errors_d = sat_inc(cnt_errors_q);
            else if (req_write) cnt_writes_d = sat_inc(cnt_writes_q);
            else                cnt_reads_d  = sat_inc(cnt_reads_q);
        end
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_reads_q  <= 32'd0;
            cnt_writes_q <= 32'd0;
            cnt_errors_q <= 32'd0;
        end else begin
            cnt_reads_q  <= cnt_reads_d;
            cnt_writes_q <= cnt_writes_d;
            cnt_errors_q <= cnt_errors_d;
        end
    end

    assign cnt_reads  = cnt_reads_q;
    assign cnt_writes = cnt_writes_q;
    assign cnt_errors = cnt_errors_q;
`else
    assign cnt_reads  = 32'd0;
    assign cnt_writes = 32'd0;
    assign cnt_errors = 32'd0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a table of requests on a 1-cycle-access
// instance, plus hand sequences for response back-pressure on a 3-cycle-access
// instance and for reset in the middle of a store.
module tb_load_store_unit;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int nchk = 0;
    int nbad = 0;
    logic both_hi = 1'b0;

    // ---------------- instance A: ACCESS_CYCLES = 1 ----------------
    logic        a_req_valid, a_req_ready, a_req_write;
    logic [31:0] a_req_addr, a_req_wdata;
    logic        a_resp_valid, a_resp_ready, a_resp_err;
    logic [31:0] a_resp_rdata;
    logic        a_mem_ren, a_mem_wen;
    logic [31:0] a_mem_addr, a_mem_din, a_mem_dout;
    logic [31:0] a_cnt_reads, a_cnt_writes, a_cnt_errors;
    logic [31:0] a_mem [0:4095];

    load_store_unit #(.ACCESS_CYCLES(1), .WORD_ADDR_BITS(12)) dut_a (
        .clock(clock), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .mem_ren(a_mem_ren), .mem_wen(a_mem_wen), .mem_addr(a_mem_addr),
        .mem_din(a_mem_din), .mem_dout(a_mem_dout),
        .cnt_reads(a_cnt_reads), .cnt_writes(a_cnt_writes), .cnt_errors(a_cnt_errors)
    );

    assign a_mem_dout = a_mem[a_mem_addr[11:0]];
    always @(posedge clock) if (a_mem_wen) a_mem[a_mem_addr[11:0]] <= a_mem_din;

    // ---------------- instance B: ACCESS_CYCLES = 3 ----------------
    logic        b_req_valid, b_req_ready, b_req_write;
    logic [31:0] b_req_addr, b_req_wdata;
    logic        b_resp_valid, b_resp_ready, b_resp_err;
    logic [31:0] b_resp_rdata;
    logic        b_mem_ren, b_mem_wen;
    logic [31:0] b_mem_addr, b_mem_din, b_mem_dout;
    logic [31:0] b_cnt_reads, b_cnt_writes, b_cnt_errors;
    logic [31:0] b_mem [0:4095];

    load_store_unit #(.ACCESS_CYCLES(3), .WORD_ADDR_BITS(12)) dut_b (
        .clock(clock), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .mem_ren(b_mem_ren), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr),
        .mem_din(b_mem_din), .mem_dout(b_mem_dout),
        .cnt_reads(b_cnt_reads), .cnt_writes(b_cnt_writes), .cnt_errors(b_cnt_errors)
    );

    assign b_mem_dout = b_mem[b_mem_addr[11:0]];
    always @(posedge clock) if (b_mem_wen) b_mem[b_mem_addr[11:0]] <= b_mem_din;

    // Enables of either instance must never overlap.
    always @(negedge clock) begin
        if ((a_mem_ren && a_mem_wen) || (b_mem_ren && b_mem_wen)) both_hi <= 1'b1;
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          ren_n;
        int          wen_n;
        logic [31:0] maddr;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction on instance A; latency counted in edges after acceptance.
    task automatic run_a(input vec_t v, input int idx);
        int k, guard, ren_n, wen_n;
        logic [31:0] maddr;
        string tag;
        tag = $sformatf("v%0d", idx);
        guard = 0;
        while (!a_req_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check({tag, " req_ready before"}, a_req_ready, 1);
        a_req_valid = 1'b1;
        a_req_write = v.wr;
        a_req_addr  = v.addr;
        a_req_wdata = v.wdata;
        @(negedge clock);
        a_req_valid = 1'b0;
        a_req_addr  = 32'hFFFF_FFFF;
        a_req_wdata = 32'h0BAD_0BAD;
        k = 0; ren_n = 0; wen_n = 0; maddr = 32'hX;
        while (!a_resp_valid && k < 40) begin
            if (a_mem_ren) ren_n++;
            if (a_mem_wen) wen_n++;
            if (a_mem_ren || a_mem_wen) maddr = a_mem_addr;
            @(negedge clock);
            k++;
        end
        check({tag, " latency"}, k, v.lat);
        check({tag, " resp_err"}, a_resp_err, v.err);
        check({tag, " resp_rdata"}, a_resp_rdata, v.rdata);
        check({tag, " ren cycles"}, ren_n, v.ren_n);
        check({tag, " wen cycles"}, wen_n, v.wen_n);
        if (v.ren_n + v.wen_n > 0) check({tag, " mem_addr"}, maddr, v.maddr);
        check({tag, " req_ready in resp"}, a_req_ready, 0);
        a_resp_ready = 1'b1;
        @(negedge clock);
        a_resp_ready = 1'b0;
        check({tag, " resp_valid after hs"}, a_resp_valid, 0);
        check({tag, " req_ready after hs"}, a_req_ready, 1);
    endtask

    initial begin
        int k, ren_n;
        logic [31:0] held;
        vec_t v;

        //          wr    addr           wdata          err   rdata          lat ren wen maddr
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         3, 0, 1, 32'd4};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 3, 1, 0, 32'd4};
        vecs[2] = '{1'b0, 32'h0000_0006, 32'h0,         1'b1, 32'h0,         1, 0, 0, 32'd0};
        vecs[3] = '{1'b1, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0,         3, 0, 1, 32'd0};
        vecs[4] = '{1'b1, 32'h0000_4000, 32'hFFFF_FFFF, 1'b1, 32'h0,         1, 0, 0, 32'd0};
        vecs[5] = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678, 3, 1, 0, 32'd0};
        vecs[6] = '{1'b1, 32'h0000_3FFC, 32'hA5A5_5A5A, 1'b0, 32'h0,         3, 0, 1, 32'hFFF};
        vecs[7] = '{1'b0, 32'h0000_3FFC, 32'h0,         1'b0, 32'hA5A5_5A5A, 3, 1, 0, 32'hFFF};
        vecs[8] = '{1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'h0,         1, 0, 0, 32'd0};
        vecs[9] = '{1'b1, 32'h0000_0002, 32'h7777_7777, 1'b1, 32'h0,         1, 0, 0, 32'd0};

        reset = 1'b1;
        a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0; a_resp_ready = 0;
        b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_resp_ready = 0;
        for (int i = 0; i < 4096; i++) begin
            a_mem[i] = 32'h0;
            b_mem[i] = 32'h0;
        end
        b_mem[8] = 32'hCAFE_F00D;
        repeat (3) @(negedge clock);

        // Reset state.
        check("rst req_ready", a_req_ready, 1);
        check("rst resp_valid", a_resp_valid, 0);
        check("rst resp_rdata", a_resp_rdata, 0);
        check("rst resp_err", a_resp_err, 0);
        check("rst mem_ren", a_mem_ren, 0);
        check("rst mem_wen", a_mem_wen, 0);
        check("rst mem_addr", a_mem_addr, 0);
        check("rst mem_din", a_mem_din, 0);
        check("rst cnt_reads", a_cnt_reads, 0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 10; i++) run_a(vecs[i], i);

        // 3 good stores, 3 good loads, 4 errors in the table.
`ifdef LSU_PERF_COUNTERS_EN
        check("cnt_writes", a_cnt_writes, 3);
        check("cnt_reads", a_cnt_reads, 3);
        check("cnt_errors", a_cnt_errors, 4);
`else
        check("cnt_writes tied", a_cnt_writes, 0);
        check("cnt_reads tied", a_cnt_reads, 0);
        check("cnt_errors tied", a_cnt_errors, 0);
`endif

        // Reset during the ACCESS cycle of a store.
        a_req_valid = 1'b1; a_req_write = 1'b1;
        a_req_addr = 32'h0000_0040; a_req_wdata = 32'h1111_1111;
        @(negedge clock);
        a_req_valid = 1'b0;
        @(negedge clock);
        check("mid-store wen high", a_mem_wen, 1);
        reset = 1'b1;
        @(negedge clock);
        check("rst-mid mem_wen", a_mem_wen, 0);
        check("rst-mid resp_valid", a_resp_valid, 0);
        check("rst-mid req_ready", a_req_ready, 1);
        check("rst-mid mem_addr", a_mem_addr, 0);
        check("rst-mid mem_din", a_mem_din, 0);
        check("rst-mid cnt_writes", a_cnt_writes, 0);
        check("rst-mid cnt_reads", a_cnt_reads, 0);
        check("rst-mid cnt_errors", a_cnt_errors, 0);
        reset = 1'b0;
        @(negedge clock);
        check("rst-mid no resp", a_resp_valid, 0);
        v = vecs[1];
        run_a(v, 10);

        // Instance B: 3-cycle access, response held off for 5 cycles.
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'h0000_0020;
        @(negedge clock);
        b_req_valid = 1'b0;
        k = 0; ren_n = 0;
        while (!b_resp_valid && k < 40) begin
            if (b_mem_ren) ren_n++;
            check("B wen during load", b_mem_wen, 0);
            @(negedge clock);
            k++;
        end
        check("B latency", k, 5);
        check("B ren cycles", ren_n, 3);
        check("B rdata", b_resp_rdata, 32'hCAFE_F00D);
        check("B err", b_resp_err, 0);
        held = b_resp_rdata;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("B stall valid", b_resp_valid, 1);
            check("B stall rdata", b_resp_rdata, held);
            check("B stall req_ready", b_req_ready, 0);
            check("B stall ren", b_mem_ren, 0);
        end
        b_resp_ready = 1'b1;
        @(negedge clock);
        b_resp_ready = 1'b0;
        check("B valid after hs", b_resp_valid, 0);
        check("B req_ready after hs", b_req_ready, 1);

        check("enables never both high", both_hi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nbad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator for the word-addressed asynchronous data memory (ren/wen/addr/din/dout responder).
- Accepts one byte-addressed load/store request at a time from the datapath.
- Converts the byte address to a word index and sequences the memory enables so that ren and wen are never both high.
- Returns read data or an error through a valid/ready response channel.

Parameters:
ACCESS_CYCLES, 1, cycles mem_ren/mem_wen stay asserted (legal range 1..15)
WORD_ADDR_BITS, 12, number of usable word-index bits in the memory (4096 words)

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
resp_valid  output  1  response present
resp_ready  input  1  datapath accepts response
resp_rdata  output  32  load data (0 for stores and errors)
resp_err  output  1  misaligned or out-of-range request
mem_ren  output  1  memory read enable
mem_wen  output  1  memory write enable
mem_addr  output  32  word index = req_addr >> 2
mem_din  output  32  memory write data
mem_dout  input  32  memory read data
cnt_reads  output  32  accepted loads (optional feature)
cnt_writes  output  32  accepted stores (optional feature)
cnt_errors  output  32  error responses (optional feature)

Behaviour:
- Interface: one clock `clock`; reset `reset` is synchronous and active-high. Everything is sampled on the rising edge of `clock`.
- Reset values: state IDLE, mem_ren=0, mem_wen=0, mem_addr=0, mem_din=0, resp_valid=0, resp_rdata=0, resp_err=0, counters=0.
- All outputs are registered except req_ready, which equals (state==IDLE).
- States: IDLE, SETUP, ACCESS, HOLD, RESP.
- IDLE: on req_valid=1, latch the request and check it.
  - Error if req_addr[1:0]!=0, or if req_addr[31:WORD_ADDR_BITS+2]!=0.
  - Error -> RESP with resp_err=1, resp_rdata=0. No enable is asserted.
  - Otherwise -> SETUP.
- SETUP (1 cycle): mem_addr = req_addr>>2. mem_din = req_wdata for a store, 0 for a load. Both enables stay 0, so the address and data are stable before any enable edge.
- ACCESS (ACCESS_CYCLES cycles): mem_wen=1 for a store, or mem_ren=1 for a load. mem_addr and mem_din are held. An internal down-counter tracks the cycles.
  - On the final ACCESS edge, resp_rdata <= mem_dout for loads (0 for stores).
  - Exit ACCESS on that edge.
- HOLD (1 cycle): both enables 0; mem_addr and mem_din are held so the write cannot land at a changing address.
- RESP: resp_valid=1 and the response fields are held stable until resp_ready=1 at an edge. That edge returns to IDLE and clears resp_valid.
- Latency: resp_valid rises ACCESS_CYCLES+2 cycles after the acceptance edge (3 for the default). Errors raise resp_valid 1 cycle after acceptance.
- Throughput: no same-cycle bypass. A new request is accepted at earliest 1 cycle after the response handshake.
- resp_ready may already be high when resp_valid rises. The handshake then completes on the next edge.
- Invariant: mem_ren & mem_wen == 0 in every cycle.
- Reset mid-operation: an in-flight access is abandoned and all outputs return to their reset values on that edge. A truncated store leaves the memory word undefined. No response is issued.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro: LSU_PERF_COUNTERS_EN.
- Defined:
  - cnt_reads increments on each accepted load that passes the checks.
  - cnt_writes increments on each accepted store that passes the checks.
  - cnt_errors increments on each error acceptance.
  - Each counter updates on the acceptance edge and saturates at 32'hFFFF_FFFF.
  - All counters clear on reset.
- Undefined: counter logic is removed and the three ports are tied to 0.

Test Plan:
1. Store req_addr=0x0000_0010, wdata=0xDEAD_BEEF, then load 0x10.
   -> mem_addr=4 in both accesses. Load resp_rdata=0xDEAD_BEEF, resp_err=0. resp_valid rises 3 cycles after each acceptance.
2. Load req_addr=0x0000_0006 -> resp_err=1, resp_rdata=0, mem_ren/mem_wen never asserted, resp_valid 1 cycle after acceptance.
3. Store req_addr=0x0000_4000 (out of range) -> resp_err=1, mem_wen stays 0. A following load of 0x0 returns the previously stored value unchanged.
4. ACCESS_CYCLES=3, load 0x20 with resp_ready held 0 for 5 cycles after resp_valid rises.
   -> mem_ren high exactly 3 cycles; resp_valid rises 5 cycles after acceptance; resp_rdata stable throughout; req_ready stays 0 until 1 cycle after the handshake.
5. Assert reset during the ACCESS cycle of a store.
   -> On the next edge mem_wen=0, resp_valid=0, req_ready=1. A new load is accepted cleanly afterwards. Both enables never high together anywhere in the run.
6. With LSU_PERF_COUNTERS_EN: 2 stores, 3 loads, 1 misaligned request -> cnt_writes=2, cnt_reads=3, cnt_errors=1. After reset all three counters read 0.
